// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared types for the data-bus arbiter slice.
//   m2s_s / s2m_s : master-to-slave request and slave-to-master response words.
//   arb_state_e   : arbiter FSM states.
//   ARB_TIMEOUT_DATA : read data returned to a master whose transaction was
//                      terminated by the watchdog (BUS_ARB_TIMEOUT_EN builds).
//   ptr_width()   : width of a round-robin pointer over n requesters (min 1).
package bus_arbiter_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } m2s_s;

  typedef struct packed {
    logic        ack;
    logic [31:0] rdata;
  } s2m_s;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  localparam logic [31:0] ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_pick.sv
// arb_rr_pick: combinational round-robin picker.
//   req_i   : request vector, one bit per requester.
//   ptr_i   : index of the last requester granted.
//   grant_o : one-hot winner (0 when no request).
//   idx_o   : winner index.
//   any_o   : at least one request present.
// Search order is ptr_i+1, ptr_i+2, ... wrapping modulo N, so the last
// winner always has the lowest priority.
module arb_rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter  int unsigned N  = 2,
  localparam int unsigned PW = ptr_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  // Vectors padded to a power of two so every PW-bit index is in range.
  localparam int unsigned NP = 1 << PW;

  logic [NP-1:0] req_pad;
  logic [NP-1:0] grant_pad;
  logic [PW-1:0] sel;

  always_comb begin
    req_pad   = NP'(req_i);
    grant_pad = '0;
    idx_o     = '0;
    any_o     = 1'b0;
    sel       = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      sel = PW'((32'(ptr_i) + k) % N);
      if (!any_o && req_pad[sel]) begin
        any_o          = 1'b1;
        grant_pad[sel] = 1'b1;
        idx_o          = sel;
      end
    end
    grant_o = grant_pad[N-1:0];
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter sharing the single bus_intercon master port
// between numMasters requesters, one transaction at a time.
//   clk, rst_b   : clock, synchronous active-low reset.
//   master_out_i : requests from the masters.
//   master_in_o  : responses to the masters; only the winner sees ack.
//   bus_out_o    : winner's request forwarded downstream (all-zero when idle).
//   bus_in_i     : response from bus_intercon.
//   grant_o      : one-hot current grant, 0 when idle.
//   busy_o       : transaction outstanding.
//   timeout_o    : sticky watchdog flag.
// Optional macro BUS_ARB_TIMEOUT_EN adds a watchdog that terminates a granted
// transaction after TIMEOUT cycles without ack; without it timeout_o is 0.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned numMasters = 2,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  m2s_s [numMasters-1:0]  master_out_i,
  output s2m_s [numMasters-1:0]  master_in_o,
  output m2s_s                   bus_out_o,
  input  s2m_s                   bus_in_i,
  output logic [numMasters-1:0]  grant_o,
  output logic                   busy_o,
  output logic                   timeout_o
);

  localparam int unsigned PW = ptr_width(numMasters);

  arb_state_e            state_q, state_d;
  logic [numMasters-1:0] grant_q, grant_d;
  logic [PW-1:0]         ptr_q, ptr_d;

  logic [numMasters-1:0] req_vec;
  logic [numMasters-1:0] pick_grant;
  logic [PW-1:0]         pick_idx;
  logic                  pick_any;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] timer_q, timer_d;
  logic          timeout_q, timeout_d;
`else
  // TIMEOUT only matters when the watchdog is built in.
  if (TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

  always_comb begin
    req_vec = '0;
    for (int unsigned i = 0; i < numMasters; i++) begin
      req_vec[i] = master_out_i[i].req;
    end
  end

  arb_rr_pick #(
    .N (numMasters)
  ) u_pick (
    .req_i   (req_vec),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    bus_out_o = '0;
    for (int unsigned i = 0; i < numMasters; i++) begin
      master_in_o[i]     = bus_in_i;
      master_in_o[i].ack = 1'b0;
    end
`ifdef BUS_ARB_TIMEOUT_EN
    timer_d   = timer_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_BUSY;
          grant_d = pick_grant;
          ptr_d   = pick_idx;
`ifdef BUS_ARB_TIMEOUT_EN
          timer_d = '0;
`endif
        end
      end
      ARB_BUSY: begin
        // ptr_q holds the current winner for the whole transaction.
        bus_out_o = master_out_i[ptr_q];
        if (bus_in_i.ack) begin
          master_in_o[ptr_q].ack = 1'b1;
          state_d = ARB_IDLE;
          grant_d = '0;
        end else if (!master_out_i[ptr_q].req) begin
          // Winner withdrew before ack: abandon without responding.
          state_d = ARB_IDLE;
          grant_d = '0;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (timer_q == TW'(TIMEOUT - 1)) begin
          master_in_o[ptr_q].ack   = 1'b1;
          master_in_o[ptr_q].rdata = ARB_TIMEOUT_DATA;
          bus_out_o.req            = 1'b0;
          timeout_d                = 1'b1;
          state_d                  = ARB_IDLE;
          grant_d                  = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= PW'(numMasters - 1);
`ifdef BUS_ARB_TIMEOUT_EN
      timer_q   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
`ifdef BUS_ARB_TIMEOUT_EN
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q == ARB_BUSY);
`ifdef BUS_ARB_TIMEOUT_EN
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst_b;
  m2s_s [N-1:0] mo;
  s2m_s [N-1:0] mi;
  m2s_s         bo;
  s2m_s         bi;
  logic [N-1:0] grant;
  logic         busy;
  logic         tmo;

  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;

  bus_arbiter #(
    .numMasters (N),
    .TIMEOUT    (8)
  ) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .master_out_i (mo),
    .master_in_o  (mi),
    .bus_out_o    (bo),
    .bus_in_i     (bi),
    .grant_o      (grant),
    .busy_o       (busy),
    .timeout_o    (tmo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "simulation time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic m2s_s rand_req();
    m2s_s r;
    r.req   = 1'b1;
    r.we    = 1'($urandom);
    r.be    = 4'($urandom);
    r.addr  = $urandom;
    r.wdata = $urandom;
    return r;
  endfunction

  task automatic test_reset();
    rst_b = 1'b0; mo = '0; bi = '0;
    step(); step(); settle();
    n_chk++; if (grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (bo !== '0) $display("FAIL reset_bus_out: got %h want 0", bo); else n_pass++;
    n_chk++; if (mi[0].ack !== 1'b0 || mi[1].ack !== 1'b0) $display("FAIL reset_acks: got %b%b want 00", mi[1].ack, mi[0].ack); else n_pass++;
    n_chk++; if (tmo !== 1'b0) $display("FAIL reset_timeout: got %b want 0", tmo); else n_pass++;
    rst_b = 1'b1;
  endtask

  task automatic test_single();
    logic [31:0] rd;
    mo[0] = rand_req();
    settle();
    n_chk++; if (grant !== 2'b00 || bo.req !== 1'b0) $display("FAIL single_latency: got grant %b req %b want 00 0", grant, bo.req); else n_pass++;
    step(); settle();
    n_chk++; if (grant !== 2'b01 || busy !== 1'b1) $display("FAIL single_grant: got %b/%b want 01/1", grant, busy); else n_pass++;
    n_chk++; if (bo !== mo[0]) $display("FAIL single_forward: got %h want %h", bo, mo[0]); else n_pass++;
    n_chk++; if (mi[0].ack !== 1'b0) $display("FAIL single_early_ack: got %b want 0", mi[0].ack); else n_pass++;
    step();
    rd = $urandom; bi.ack = 1'b1; bi.rdata = rd;
    settle();
    n_chk++; if (mi[0].ack !== 1'b1 || mi[0].rdata !== rd) $display("FAIL single_resp: got %b/%h want 1/%h", mi[0].ack, mi[0].rdata, rd); else n_pass++;
    n_chk++; if (mi[1].ack !== 1'b0) $display("FAIL single_other_ack: got %b want 0", mi[1].ack); else n_pass++;
    n_chk++; if (grant !== 2'b01 || bo.req !== 1'b1) $display("FAIL single_hold: got %b/%b want 01/1", grant, bo.req); else n_pass++;
    step();
    mo[0].req = 1'b0; bi = '0;
    settle();
    n_chk++; if (grant !== 2'b00 || busy !== 1'b0 || bo.req !== 1'b0) $display("FAIL single_release: got %b/%b/%b want 00/0/0", grant, busy, bo.req); else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 3; t++) begin
      mo[1] = rand_req(); bi = '0;
      settle();
      n_chk++; if (grant !== 2'b00) $display("FAIL b2b_bubble[%0d]: got %b want 00", t, grant); else n_pass++;
      step(); settle();
      n_chk++; if (grant !== 2'b10 || bo !== mo[1]) $display("FAIL b2b_grant[%0d]: got %b/%h want 10/%h", t, grant, bo, mo[1]); else n_pass++;
      bi.ack = 1'b1; bi.rdata = $urandom;
      settle();
      n_chk++; if (mi[1].ack !== 1'b1 || mi[0].ack !== 1'b0) $display("FAIL b2b_ack[%0d]: got %b%b want 10", t, mi[1].ack, mi[0].ack); else n_pass++;
      step();
    end
    mo = '0; bi = '0;
    step();
  endtask

  task automatic test_round_robin();
    int w;
    logic [N-1:0] eg;
    mo[0] = rand_req(); mo[1] = rand_req(); bi = '0;
    for (int g = 0; g < 4; g++) begin
      w = g % 2;
      eg = '0; eg[w] = 1'b1;
      settle();
      n_chk++; if (grant !== 2'b00) $display("FAIL rr_bubble[%0d]: got %b want 00", g, grant); else n_pass++;
      step(); settle();
      n_chk++; if (grant !== eg || bo !== mo[w]) $display("FAIL rr_grant[%0d]: got %b want %b", g, grant, eg); else n_pass++;
      n_chk++; if (mi[1-w].ack !== 1'b0) $display("FAIL rr_idle_ack[%0d]: got %b want 0", g, mi[1-w].ack); else n_pass++;
      step();
      bi.ack = 1'b1; bi.rdata = $urandom;
      settle();
      n_chk++; if (mi[w].ack !== 1'b1 || mi[1-w].ack !== 1'b0) $display("FAIL rr_ack[%0d]: got winner %b other %b want 1 0", g, mi[w].ack, mi[1-w].ack); else n_pass++;
      step();
      bi.ack = 1'b0;
    end
    mo = '0; bi = '0;
    step();
  endtask

  task automatic test_reset_mid();
    mo[1] = rand_req(); bi = '0;
    step(); settle();
    n_chk++; if (grant !== 2'b10) $display("FAIL rstmid_pre_grant: got %b want 10", grant); else n_pass++;
    rst_b = 1'b0;
    step(); settle();
    n_chk++; if (grant !== 2'b00 || busy !== 1'b0 || bo.req !== 1'b0 || mi[1].ack !== 1'b0) $display("FAIL rstmid_drop: got %b/%b/%b/%b want 00/0/0/0", grant, busy, bo.req, mi[1].ack); else n_pass++;
    rst_b = 1'b1; mo[0] = rand_req();
    step(); settle();
    n_chk++; if (grant !== 2'b01) $display("FAIL rstmid_ptr: got %b want 01", grant); else n_pass++;
    bi.ack = 1'b1;
    step();
    mo = '0; bi = '0;
    step();
  endtask

  task automatic test_abandon();
    mo[0] = rand_req(); bi = '0;
    step(); settle();
    n_chk++; if (grant !== 2'b01) $display("FAIL abandon_grant: got %b want 01", grant); else n_pass++;
    mo[0].req = 1'b0; mo[1] = rand_req();
    settle();
    n_chk++; if (bo.req !== 1'b0 || mi[0].ack !== 1'b0) $display("FAIL abandon_fwd: got req %b ack %b want 0 0", bo.req, mi[0].ack); else n_pass++;
    step(); settle();
    n_chk++; if (grant !== 2'b00 || busy !== 1'b0) $display("FAIL abandon_idle: got %b/%b want 00/0", grant, busy); else n_pass++;
    step(); settle();
    n_chk++; if (grant !== 2'b10 || bo !== mo[1]) $display("FAIL abandon_next: got %b want 10", grant); else n_pass++;
    bi.ack = 1'b1;
    step();
    mo = '0; bi = '0;
    step();
  endtask

  // Transaction-level reference: owner = master holding the bus (-1 idle),
  // last = most recently granted master.
  task automatic test_random();
    int owner, last, scnt, slat, c;
    int gap[N];
    bit done[N];
    logic [N-1:0] req_s, eg;
    logic ack_s;
    m2s_s eb;
    rst_b = 1'b0; mo = '0; bi = '0;
    step();
    rst_b = 1'b1;
    owner = -1; last = N - 1; scnt = 0; slat = 0;
    for (int i = 0; i < N; i++) begin gap[i] = $urandom_range(0, 3); done[i] = 1'b0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          mo[i].req = 1'b0; done[i] = 1'b0; gap[i] = $urandom_range(0, 3);
        end else if (!mo[i].req) begin
          if (gap[i] == 0) mo[i] = rand_req(); else gap[i]--;
        end else if (owner == i && $urandom_range(0, 19) == 0) begin
          mo[i].req = 1'b0; gap[i] = $urandom_range(0, 3);
        end
      end
      bi.rdata = $urandom;
      bi.ack   = (owner >= 0) && mo[owner].req && (scnt >= slat);
      settle();
      eg = '0; eb = '0;
      if (owner >= 0) begin eg[owner] = 1'b1; eb = mo[owner]; end
      n_chk++; if (grant !== eg || busy !== (owner >= 0)) $display("FAIL rand_grant@%0d: got %b/%b want %b", cyc, grant, busy, eg); else n_pass++;
      n_chk++; if (bo !== eb) $display("FAIL rand_bus_out@%0d: got %h want %h", cyc, bo, eb); else n_pass++;
      for (int i = 0; i < N; i++) begin
        n_chk++;
        if (mi[i].ack !== (owner == i && bi.ack) || mi[i].rdata !== bi.rdata)
          $display("FAIL rand_resp%0d@%0d: got %b/%h want %b/%h", i, cyc, mi[i].ack, mi[i].rdata, (owner == i && bi.ack), bi.rdata);
        else n_pass++;
      end
      for (int i = 0; i < N; i++) req_s[i] = mo[i].req;
      ack_s = bi.ack;
      step();
      if (owner >= 0) begin
        if (ack_s) begin done[owner] = 1'b1; owner = -1; end
        else if (!req_s[owner]) owner = -1;
        else scnt++;
      end else begin
        for (int k = 1; k <= N; k++) begin
          c = (last + k) % N;
          if (owner < 0 && req_s[c]) owner = c;
        end
        if (owner >= 0) begin last = owner; scnt = 0; slat = $urandom_range(0, 3); end
      end
    end
    mo = '0; bi = '0;
    step(); step();
    n_chk++; if (tmo !== 1'b0) $display("FAIL rand_timeout_flag: got %b want 0", tmo); else n_pass++;
  endtask

`ifdef BUS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] rd;
    rst_b = 1'b0; mo = '0; bi = '0;
    step();
    rst_b = 1'b1; mo[0] = rand_req();
    step();
    for (int c = 1; c <= 8; c++) begin
      settle();
      if (c < 8) begin
        n_chk++; if (mi[0].ack !== 1'b0 || bo.req !== 1'b1) $display("FAIL to_wait[%0d]: got ack %b req %b want 0 1", c, mi[0].ack, bo.req); else n_pass++;
      end else begin
        n_chk++; if (mi[0].ack !== 1'b1 || mi[0].rdata !== 32'hDEADBEEF) $display("FAIL to_expire: got %b/%h want 1/deadbeef", mi[0].ack, mi[0].rdata); else n_pass++;
        n_chk++; if (bo.req !== 1'b0 || mi[1].ack !== 1'b0) $display("FAIL to_drop_req: got req %b m1ack %b want 0 0", bo.req, mi[1].ack); else n_pass++;
      end
      step();
    end
    mo[0].req = 1'b0;
    settle();
    n_chk++; if (tmo !== 1'b1 || grant !== 2'b00) $display("FAIL to_flag: got %b/%b want 1/00", tmo, grant); else n_pass++;
    step(); step(); step();
    n_chk++; if (tmo !== 1'b1) $display("FAIL to_sticky: got %b want 1", tmo); else n_pass++;
    rst_b = 1'b0;
    step();
    rst_b = 1'b1; mo[0] = rand_req();
    step();
    for (int c = 1; c <= 8; c++) begin
      if (c == 8) begin rd = $urandom; bi.ack = 1'b1; bi.rdata = rd; end
      settle();
      if (c == 8) begin
        n_chk++; if (mi[0].ack !== 1'b1 || mi[0].rdata !== rd) $display("FAIL to_real_ack: got %b/%h want 1/%h", mi[0].ack, mi[0].rdata, rd); else n_pass++;
      end
      step();
    end
    mo = '0; bi = '0;
    settle();
    n_chk++; if (tmo !== 1'b0) $display("FAIL to_no_flag: got %b want 0", tmo); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_round_robin();
    test_reset_mid();
    test_abandon();
    test_random();
`ifdef BUS_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter that shares the single master port of the data-bus bus_intercon between numMasters requesters, e.g. jpu_core data port plus a DMA/debug loader.
- Sits between the masters and bus_intercon.bus_master_out_i/bus_master_in_o.
- Grants one transaction at a time.
- Forwards the winner's bus::m2s_s downstream and routes bus::s2m_s back to the winner only.

Parameters:
- numMasters, 2, number of requesting masters (1..8).
- TIMEOUT, 256, cycles a granted transaction may wait for ack before forced termination (used only with BUS_ARB_TIMEOUT_EN).

Ports:
- clk  input  1  system clock.
- rst_b  input  1  synchronous active-low reset.
- master_out_i  input  bus::m2s_s [numMasters-1:0]  requests from masters.
- master_in_o  output  bus::s2m_s [numMasters-1:0]  responses to masters.
- bus_out_o  output  bus::m2s_s  to bus_intercon master input.
- bus_in_i  input  bus::s2m_s  from bus_intercon master output.
- grant_o  output  numMasters  one-hot current grant, 0 when idle.
- busy_o  output  1  transaction outstanding.
- timeout_o  output  1  sticky timeout flag; tied 0 without BUS_ARB_TIMEOUT_EN.

Behaviour:
- Handshake uses only m2s_s.req and s2m_s.ack. All other fields pass through unchanged.
- Master protocol: raise req with stable fields and hold until ack, which lasts one cycle.
- Reset (rst_b=0 at posedge): state=IDLE, grant_o=0, busy_o=0, last grant pointer=numMasters-1, timeout_o=0, timer=0.
  - bus_out_o is all-zero while idle, so req=0.
  - Every master_in_o[i].ack=0.
- State IDLE:
  - If any master_out_i[i].req, pick the first requester at index (ptr+1) mod numMasters, ptr+2, ... wrapping.
  - Register a one-hot grant, set ptr=winner, go to BUSY.
  - Arbitration latency is 1 cycle: req seen at edge N, downstream req at N+1.
- State BUSY:
  - bus_out_o = master_out_i[winner].
  - master_in_o[winner] = bus_in_i.
  - Every other master_in_o[j] gets bus_in_i data with ack forced 0.
- BUSY -> IDLE on bus_in_i.ack: grant_o clears the next cycle. There is one mandatory idle bubble between grants.
- Winner drops req before ack (protocol violation): abandon and go to IDLE next cycle. No ack is delivered.
- Simultaneous requests: strict round-robin. A master just served has lowest priority next arbitration. With numMasters=1, it is granted every other cycle.
- Requests arriving during BUSY are held pending by the requester. Nothing is queued inside the arbiter.
- Synchronous reset mid-transaction: grant drops immediately at that edge, downstream req goes 0, and no ack is issued.
- ptr wraps modulo numMasters. Width is $clog2(numMasters), minimum 1.

Optional Feature:
- Macro BUS_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT-1 with no ack, the arbiter returns a one-cycle ack to the winner with data 32'hDEAD_BEEF, sets timeout_o (sticky until reset), drops bus_out_o.req and goes to IDLE.
  - A real ack in the same cycle as expiry wins: normal response, no flag.
- Not defined: no counter logic; a transaction waits indefinitely; timeout_o=0.

Decomposition:
- Package bus gains:
  - typedef enum arb_state_e {ARB_IDLE, ARB_BUSY}.
  - localparam ARB_TIMEOUT_DATA = 32'hDEAD_BEEF.
- Sub-module arb_rr_pick: combinational round-robin picker.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, winner index, any.
  - Reused later by the instruction-bus arbiter.

Test Plan:
- Reset then single request: m0 req at cycle 2; slave acks cycle 4.
  - Required: bus_out_o.req=1 cycles 3..4; master_in_o[0].ack=1 in cycle 4 only; grant_o=2'b01 cycles 3..4, 0 in cycle 5.
- Simultaneous m0,m1 held continuously, slave acks 1 cycle after req:
  - Grant order m0, m1, m0, m1 with one idle cycle between.
  - m1 never sees ack during m0 grant.
- Back-to-back same master: m1 alone issues 3 transactions.
  - All served; ptr=1 each time; idle bubble present.
- Reset mid-transaction: rst_b=0 while BUSY with m1.
  - Next cycle grant_o=0, busy_o=0, bus_out_o.req=0, no ack to m1.
  - After reset, m0 and m1 both requesting: m0 wins (ptr reset value numMasters-1).
- Abandon: m0 granted, drops req before ack.
  - IDLE next cycle; pending m1 granted the cycle after.
- BUS_ARB_TIMEOUT_EN, TIMEOUT=8: slave never acks.
  - m0 gets ack with data 32'hDEADBEEF in the 8th BUSY cycle; timeout_o=1 and stays 1.
  - Same run with an ack on cycle 8 → normal data, timeout_o=0.
